step_reply_tx: RTL and testbench
================================

# step_reply_tx

Serial transmitter for the pipeline debug link. The host issues single-character commands, for example the step command 0x73 ('s'). This block sends the reply frame back to the host. On a one-cycle request it latches a 32-bit debug word and sends a 5-byte frame over a UART 8N1 line: the echo byte 0x73, then the word MSB-first. It sits between the debug controller, which pulses the request after a step completes, and the board TX pin.

## Interface
Parameters:
- CLKS_PER_BIT, default 5208: clock cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
- ECHO_BYTE, default 8'h73: first byte of every frame.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- inStart  in  1  frame request, sampled only while idle.
- inDato  in  32  debug word, latched in the cycle inStart is accepted.
- outTx  out  1  serial line, idle high.
- outBusy  out  1  high from the cycle after acceptance until the frame ends.
- outDone  out  1  one-cycle pulse at frame end.

## Operation
Reset (rst_n low) takes effect immediately, without waiting for a clock edge:
- outTx=1, outBusy=0, outDone=0.
- State IDLE; all counters and the shift register cleared.
- A frame in progress is abandoned with no partial stop bit.

State machine, one state per bit type:
- IDLE → START when inStart=1.
  - On that edge, latch {ECHO_BYTE, inDato[31:24], inDato[23:16], inDato[15:8], inDato[7:0]} into a 40-bit frame register.
  - Set byte index = 0.
- START: outTx=0 for CLKS_PER_BIT cycles, then → DATA with bit index 0.
- DATA: outTx = current byte[bit index], LSB first; each bit lasts CLKS_PER_BIT cycles. After bit 7 → STOP.
- STOP: outTx=1 for CLKS_PER_BIT cycles.
  - If byte index < 4: increment the index, → START.
  - Else: → IDLE and pulse outDone.

Counter widths:
- Baud counter: clog2(CLKS_PER_BIT) bits; counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary.
- Bit index: 3 bits. Byte index: 3 bits.
- No other arithmetic.

Acceptance and data rules:
- inStart is ignored while outBusy=1; the request is not queued.
- inDato changes after acceptance do not affect the frame in flight.
- outTx is registered and never glitches.

## Timing
- Accept edge E: the rising edge where state=IDLE and inStart=1.
- Outputs after E: outTx=0 and outBusy=1 starting the cycle after E, which is 1 cycle of latency.
- Frame length: 5 bytes × 10 bits × CLKS_PER_BIT cycles = 50·CLKS_PER_BIT cycles of outBusy=1.
- Frame end: in the cycle after the last stop bit's final cycle, outBusy=0 and outDone=1, for exactly one cycle.
- Back-to-back frames: if inStart=1 during the outDone cycle, the state is IDLE, so the request is accepted. The next start bit begins the following cycle, with no extra idle bit time.
- Bit boundaries: every bit is exactly CLKS_PER_BIT cycles, with no drift across bytes.
- Held request: inStart held high continuously produces back-to-back frames.
- Reset release: first acceptance is possible on the first rising edge with rst_n=1.

## Test plan
Sim parameter CLKS_PER_BIT=4 unless noted.
- Basic frame. Stimulus: pulse inStart with inDato=32'h12345678. Required response:
  - outTx decodes (sample mid-bit) to 0x73, 0x12, 0x34, 0x56, 0x78.
  - outBusy high exactly 200 cycles.
  - outDone a single pulse on cycle 201 after E.
- Ignored start. Stimulus: pulse inStart at cycles 10 and 100 after E, with a different inDato each time. Required response: frame unchanged, no second frame queued, outDone pulses once.
- Back-to-back. Stimulus: assert inStart with inDato=32'hA5A5A5A5 coincident with outDone. Required response:
  - The second frame's start bit begins the cycle immediately after outDone.
  - The frame decodes to 0x73, 0xA5, 0xA5, 0xA5, 0xA5.
- Reset mid-frame. Stimulus: drop rst_n asynchronously (between clock edges) during DATA of byte 2. Required response:
  - outTx=1 and outBusy=0 immediately, with no outDone.
  - After release, a fresh inStart with 32'h00000000 yields 0x73, 0x00, 0x00, 0x00, 0x00.
- Data latch stability. Stimulus: change inDato every cycle after acceptance. Required response: the frame carries only the value present at E.
- Minimum divider. Stimulus: CLKS_PER_BIT=2 with inDato=32'hFFFFFFFF. Required response: every bit lasts exactly 2 cycles, and the total busy time is 100 cycles.

Source files
------------

// File: rtl/step_reply_tx.sv
// step_reply_tx
//   Sends the reply frame for a debug-link command. A one-cycle request
//   latches a 32-bit debug word. The block then sends five UART 8N1 bytes,
//   LSB-first within each byte: the echo byte, then the word MSB-first.
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   inStart  frame request, only looked at while idle
//   inDato   debug word, captured on the accepting edge
//   outTx    registered serial line, idle high
//   outBusy  high while a frame is on the line
//   outDone  one-cycle pulse in the cycle after the last stop bit
module step_reply_tx #(
    parameter int          CLKS_PER_BIT = 5208,
    parameter logic [7:0]  ECHO_BYTE    = 8'h73
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inStart,
    input  logic [31:0] inDato,
    output logic        outTx,
    output logic        outBusy,
    output logic        outDone
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [2:0]    byte_idx, byte_n;
    logic [39:0]   frame, frame_n;
    logic          tx, tx_n;
    logic          busy, busy_n;
    logic          done, done_n;

    // The byte on the wire is always the top byte of the frame register.
    // The register shifts left by one byte at each stop-to-start hand-off.
    logic [7:0] cur_byte;
    logic       bit_end;

    assign cur_byte = frame[39:32];
    assign bit_end  = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            frame    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            frame    <= frame_n;
            tx       <= tx_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Every output is computed one cycle ahead, so outTx comes straight from a flop.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        frame_n = frame;
        tx_n    = tx;
        busy_n  = busy;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (inStart) begin
                    state_n = START;
                    frame_n = {ECHO_BYTE, inDato};
                    byte_n  = '0;
                    cnt_n   = '0;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = DATA;
                    tx_n    = cur_byte[0];
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                        tx_n  = cur_byte[bit_idx + 3'd1];
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (byte_idx != 3'd4) begin
                        byte_n  = byte_idx + 3'd1;
                        frame_n = {frame[31:0], 8'h00};
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        // The line is already high from the stop bit, so only the flags change.
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign outTx   = tx;
    assign outBusy = busy;
    assign outDone = done;

endmodule

// File: tb/tb_step_reply_tx.sv
// tb_step_reply_tx
//   Self-checking bench for step_reply_tx. One instance runs at four clocks
//   per bit and a second runs at two clocks per bit. Expected line levels
//   come from a bit-list model of the 8N1 frame built from the word that was
//   present on the accepting edge.
module tb_step_reply_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start4, start2;
    logic [31:0] dato;
    logic        tx4, busy4, done4;
    logic        tx2, busy2, done2;

    int sel_c  = 4;
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    step_reply_tx #(.CLKS_PER_BIT(4), .ECHO_BYTE(8'h73)) dut4 (
        .clk(clk), .rst_n(rst_n), .inStart(start4), .inDato(dato),
        .outTx(tx4), .outBusy(busy4), .outDone(done4)
    );

    step_reply_tx #(.CLKS_PER_BIT(2), .ECHO_BYTE(8'h73)) dut2 (
        .clk(clk), .rst_n(rst_n), .inStart(start2), .inDato(dato),
        .outTx(tx2), .outBusy(busy2), .outDone(done2)
    );

    typedef struct {
        logic [31:0] word;
        logic [39:0] exp;
    } vec_t;

    // The model is the 50-bit line sequence: per byte a 0, eight data bits LSB-first, then a 1.
    function automatic logic [39:0] model_frame(input logic [31:0] w);
        return {8'h73, w};
    endfunction

    function automatic logic model_bit(input logic [39:0] f, input int idx);
        int         by;
        int         pos;
        logic [7:0] b;
        by  = idx / 10;
        pos = idx % 10;
        b   = f[39 - 8*by -: 8];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos - 1];
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic get_out(output logic t, output logic b, output logic d);
        if (sel_c == 2) begin t = tx2; b = busy2; d = done2; end
        else            begin t = tx4; b = busy4; d = done4; end
    endtask

    task automatic set_start(input logic v);
        if (sel_c == 2) start2 = v;
        else            start4 = v;
    endtask

    // Called just after the active edge; the next edge accepts the request.
    task automatic start_frame(input logic [31:0] w);
        dato = w;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
    endtask

    // Entered in the first cycle after the accepting edge and left in the outDone cycle.
    task automatic run_frame(input logic [31:0] w, input bit scramble, input bit pokes,
                             input bit hold, input string nm, output logic [39:0] dec);
        int          c;
        int          total;
        int          nbusy;
        int          ndone;
        int          idx;
        int          pos;
        logic        t, b, d;
        logic [2:0]  expv;
        logic [39:0] f;
        c     = sel_c;
        total = 50 * c;
        nbusy = 0;
        ndone = 0;
        dec   = '0;
        f     = model_frame(w);
        for (int k = 1; k <= total + 1; k++) begin
            get_out(t, b, d);
            if (k <= total) expv = {model_bit(f, (k - 1) / c), 1'b1, 1'b0};
            else            expv = 3'b101;
            chk(nm, 64'({t, b, d}), 64'(expv));
            nbusy += int'(b);
            ndone += int'(d);
            if (k <= total && ((k - 1) % c) == c / 2) begin
                idx = (k - 1) / c;
                pos = idx % 10;
                if (pos >= 1 && pos <= 8) dec[32 - 8*(idx / 10) + pos - 1] = t;
            end
            if (k == total + 1) break;
            if (scramble) dato = $urandom;
            if (pokes && (k == 10 || k == 100)) dato = $urandom;
            set_start(hold || (pokes && (k == 10 || k == 100)));
            @(posedge clk); #1;
        end
        chk({nm, " decode"}, 64'(dec), 64'(f));
        chk({nm, " busy cycles"}, 64'(nbusy), 64'(total));
        chk({nm, " done pulses"}, 64'(ndone), 64'(1));
    endtask

    task automatic idle_check(input string nm);
        logic t, b, d;
        set_start(1'b0);
        @(posedge clk); #1;
        get_out(t, b, d);
        chk(nm, 64'({t, b, d}), 64'(3'b100));
    endtask

    initial begin
        vec_t        tbl[4];
        logic [39:0] dec;
        logic [31:0] w;
        logic        t, b, d;

        tbl[0] = '{32'h12345678, 40'h7312345678};
        tbl[1] = '{32'hDEADBEEF, 40'h73DEADBEEF};
        tbl[2] = '{32'h00000000, 40'h7300000000};
        tbl[3] = '{32'h80000001, 40'h7380000001};

        rst_n  = 1'b0;
        start4 = 1'b0;
        start2 = 1'b0;
        dato   = '0;
        #12;
        sel_c = 4; get_out(t, b, d); chk("reset dut4", 64'({t, b, d}), 64'(3'b100));
        sel_c = 2; get_out(t, b, d); chk("reset dut2", 64'({t, b, d}), 64'(3'b100));
        sel_c = 4;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table frames. The first one is accepted on the first edge after reset release.
        for (int i = 0; i < 4; i++) begin
            start_frame(tbl[i].word);
            run_frame(tbl[i].word, 1'b0, 1'b0, 1'b0, "table", dec);
            chk("table bytes", 64'(dec), 64'(tbl[i].exp));
            idle_check("table idle");
        end

        // Requests made while busy must neither alter nor queue a frame.
        start_frame(32'hCAFEF00D);
        run_frame(32'hCAFEF00D, 1'b0, 1'b1, 1'b0, "ignored", dec);
        for (int i = 0; i < 5; i++) idle_check("ignored no queue");

        // inDato changes on every cycle after acceptance.
        start_frame(32'h5EC0DE42);
        run_frame(32'h5EC0DE42, 1'b1, 1'b0, 1'b0, "latch", dec);
        idle_check("latch idle");

        // A request in the outDone cycle starts a frame with no idle gap.
        start_frame(32'h0F0F1234);
        run_frame(32'h0F0F1234, 1'b0, 1'b0, 1'b0, "b2b first", dec);
        dato = 32'hA5A5A5A5;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        run_frame(32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, "b2b second", dec);
        chk("b2b bytes", 64'(dec), 64'(40'h73A5A5A5A5));
        idle_check("b2b idle");

        // inStart held high gives back-to-back frames.
        dato = 32'h13579BDF;
        set_start(1'b1);
        @(posedge clk); #1;
        run_frame(32'h13579BDF, 1'b0, 1'b0, 1'b1, "held first", dec);
        @(posedge clk); #1;
        run_frame(32'h13579BDF, 1'b0, 1'b0, 1'b0, "held second", dec);
        idle_check("held idle");

        // Random words with random input disturbance.
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            start_frame(w);
            run_frame(w, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0, "random", dec);
            idle_check("random idle");
        end

        // Asynchronous reset during the data bits of byte 2.
        start_frame($urandom);
        repeat (91) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        get_out(t, b, d);
        chk("reset immediate", 64'({t, b, d}), 64'(3'b100));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            get_out(t, b, d);
            chk("reset held", 64'({t, b, d}), 64'(3'b100));
        end
        rst_n = 1'b1;
        start_frame(32'h00000000);
        run_frame(32'h00000000, 1'b0, 1'b0, 1'b0, "after reset", dec);
        chk("after reset bytes", 64'(dec), 64'(40'h7300000000));
        idle_check("after reset idle");

        // Two clocks per bit.
        sel_c = 2;
        start_frame(32'hFFFFFFFF);
        run_frame(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, "min div", dec);
        chk("min div bytes", 64'(dec), 64'(40'h73FFFFFFFF));
        idle_check("min div idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
